// File: rtl/sobel_magnitude.sv
// sobel_magnitude
//   Final stage after the 3x3 gradient convolvers. Takes a signed gx/gy pair
//   per pixel and produces a saturated unsigned gradient magnitude plus a
//   binary edge flag. It tracks the raster position and zeroes the border
//   pixels that fall inside the window warm-up region. The block is a
//   two-stage registered pipeline with a valid/ready handshake on each side.
//
//   Optional build macro: SOBEL_MAG_MAXMIN_EN
//     defined   -> raw = max(ax,ay) + (min(ax,ay) >> 1)  (alpha-max/beta-min)
//     undefined -> raw = ax + ay                          (L1 magnitude)
//
// Ports
//   clk_i        clock
//   rstn_i       asynchronous, active-low reset
//   valid_i      upstream gx/gy valid
//   ready_o      block can accept this cycle (combinational)
//   gx_i, gy_i   signed gradients, 2*WIDTH_P bits wide
//   threshold_i  edge threshold, sampled when a pixel enters stage 2
//   valid_o      output valid
//   ready_i      downstream ready
//   mag_o        saturated magnitude, WIDTH_P bits
//   edge_o       mag_o > threshold_i
//   sof_o        output pixel is col 0 / row 0 of a frame
module sobel_magnitude #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16,
  parameter int SHIFT_P  = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2*WIDTH_P-1:0]   gx_i,
  input  logic [2*WIDTH_P-1:0]   gy_i,
  input  logic [WIDTH_P-1:0]     threshold_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH_P-1:0]     mag_o,
  output logic                   edge_o,
  output logic                   sof_o
);

  localparam int GW = 2 * WIDTH_P;
  localparam int CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
  localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

  localparam logic [GW-1:0] ABS_MAX = {1'b0, {(GW-1){1'b1}}};
  localparam logic [GW-1:0] NEG_MIN = {1'b1, {(GW-1){1'b0}}};
  localparam logic [GW:0]   MAG_MAX = {{(GW+1-WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

  // |v| in GW bits; the most-negative code has no positive twin, so clamp it.
  function automatic logic [GW-1:0] abs_sat(input logic [GW-1:0] v);
    logic [GW-1:0] r;
    if (v == NEG_MIN)  r = ABS_MAX;
    else if (v[GW-1])  r = ~v + 1'b1;
    else               r = v;
    return r;
  endfunction

  // Handshake
  logic v1_q, v2_q;
  logic en1, en2, accept;

  assign en2     = ~v2_q | ready_i;
  assign en1     = ~v1_q | en2;
  assign ready_o = en1;
  assign accept  = valid_i & en1;
  assign valid_o = v2_q;

  // Raster position of the pixel currently offered on the input
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(DEPTH_P - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT_P - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Stage 1: absolute values, border mask, start-of-frame tag
  logic [GW-1:0] ax_q, ay_q;
  logic          msk1_q, sof1_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q   <= 1'b0;
      ax_q   <= '0;
      ay_q   <= '0;
      msk1_q <= 1'b0;
      sof1_q <= 1'b0;
    end else if (en1) begin
      v1_q   <= accept;
      ax_q   <= abs_sat(gx_i);
      ay_q   <= abs_sat(gy_i);
      // The first two columns/rows never see a full 3x3 window upstream.
      msk1_q <= (col_q < CW'(2)) | (row_q < RW'(2));
      sof1_q <= (col_q == '0) & (row_q == '0);
    end
  end

  // Stage 2 combinational: magnitude, shift, saturate, mask, threshold
  logic [GW:0]        raw, shifted;
  logic [WIDTH_P-1:0] mag_sat, mag_d;
  logic               edge_d;

`ifdef SOBEL_MAG_MAXMIN_EN
  logic [GW-1:0] mx, mn;
  always_comb begin
    mx  = (ax_q >= ay_q) ? ax_q : ay_q;
    mn  = (ax_q >= ay_q) ? ay_q : ax_q;
    raw = {1'b0, mx} + {2'b00, mn[GW-1:1]};
  end
`else
  assign raw = {1'b0, ax_q} + {1'b0, ay_q};
`endif

  always_comb begin
    shifted = raw >> SHIFT_P;
    mag_sat = (shifted > MAG_MAX) ? {WIDTH_P{1'b1}} : shifted[WIDTH_P-1:0];
    mag_d   = msk1_q ? '0 : mag_sat;
    edge_d  = ~msk1_q & (mag_sat > threshold_i);
  end

  logic [WIDTH_P-1:0] mag_q;
  logic               edge_q, sof2_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v2_q   <= 1'b0;
      mag_q  <= '0;
      edge_q <= 1'b0;
      sof2_q <= 1'b0;
    end else if (en2) begin
      v2_q   <= v1_q;
      mag_q  <= mag_d;
      edge_q <= edge_d;
      sof2_q <= sof1_q;
    end
  end

  assign mag_o  = mag_q;
  assign edge_o = edge_q;
  assign sof_o  = sof2_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
// tb_sobel_magnitude
//   Directed bench for sobel_magnitude with default parameters
//   (WIDTH_P=8, DEPTH_P=16, HEIGHT_P=16, SHIFT_P=2). A monitor logs every
//   output transfer; each test task compares against hand-computed values.
module tb_sobel_magnitude;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] gx_i, gy_i;
  logic [7:0]  threshold_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  mag_o;
  logic        edge_o;
  logic        sof_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q_mag[$];
  logic       q_edge[$];
  logic       q_sof[$];

  sobel_magnitude dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .gx_i(gx_i), .gy_i(gy_i), .threshold_i(threshold_i), .valid_o(valid_o),
    .ready_i(ready_i), .mag_o(mag_o), .edge_o(edge_o), .sof_o(sof_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rstn_i && valid_o && ready_i) begin
      q_mag.push_back(mag_o);
      q_edge.push_back(edge_o);
      q_sof.push_back(sof_o);
    end
  end

`ifdef SOBEL_MAG_MAXMIN_EN
  localparam logic [7:0] EXP_40_24 = 8'd13;  // 40 + 12 = 52, >>2
  localparam logic       EXP_E15   = 1'b0;
  localparam logic [7:0] EXP_100   = 8'd37;  // 100 + 50 = 150, >>2
`else
  localparam logic [7:0] EXP_40_24 = 8'd16;  // 40 + 24 = 64, >>2
  localparam logic       EXP_E15   = 1'b1;
  localparam logic [7:0] EXP_100   = 8'd50;  // 200, >>2
`endif

  task automatic clear_q();
    q_mag.delete(); q_edge.delete(); q_sof.delete();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    gx_i = '0; gy_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    clear_q();
  endtask

  // Feed n identical pixels back-to-back; returns at #1 after the last accept.
  task automatic stream_const(input int n, input logic [15:0] gx, input logic [15:0] gy);
    int t;
    valid_i = 1'b1; gx_i = gx; gy_i = gy;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!ready_o && t < 50) begin @(posedge clk_i); #1; t++; end
      if (t >= 50) begin
        n_chk++; n_fail++;
        $display("FAIL stream_timeout: ready_o stuck low, required 1");
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_chk++; if (mag_o !== 8'd0)   begin n_fail++; $display("FAIL rst_mag: got %0d want 0", mag_o); end
    n_chk++; if (edge_o !== 1'b0)  begin n_fail++; $display("FAIL rst_edge: got %b want 0", edge_o); end
    n_chk++; if (sof_o !== 1'b0)   begin n_fail++; $display("FAIL rst_sof: got %b want 0", sof_o); end
  endtask

  task automatic test_basic();
    do_reset();
    threshold_i = 8'd15;
    stream_const(53, 16'd0, 16'd0);       // advance to col 5, row 3
    drain();
    stream_const(1, 16'd40, -16'sd24);
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_early: valid_o %b want 0", valid_o); end
    @(posedge clk_i); #1;
    n_chk++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_valid: valid_o %b want 1", valid_o); end
    n_chk++; if (mag_o !== EXP_40_24) begin n_fail++; $display("FAIL basic_mag: got %0d want %0d", mag_o, EXP_40_24); end
    n_chk++; if (edge_o !== EXP_E15) begin n_fail++; $display("FAIL basic_edge_t15: got %b want %b", edge_o, EXP_E15); end
    drain();
    threshold_i = 8'd16;                  // col 6: equal-to-threshold is not an edge
    stream_const(1, 16'd40, -16'sd24);
    @(posedge clk_i); #1;
    n_chk++; if (mag_o !== EXP_40_24) begin n_fail++; $display("FAIL basic_mag2: got %0d want %0d", mag_o, EXP_40_24); end
    n_chk++; if (edge_o !== 1'b0) begin n_fail++; $display("FAIL basic_edge_t16: got %b want 0", edge_o); end
    drain();
    stream_const(1, 16'h8000, 16'h7fff); // col 7: saturation
    @(posedge clk_i); #1;
    n_chk++; if (mag_o !== 8'd255) begin n_fail++; $display("FAIL sat_mag: got %0d want 255", mag_o); end
    n_chk++; if (edge_o !== 1'b1) begin n_fail++; $display("FAIL sat_edge: got %b want 1", edge_o); end
    drain();
  endtask

  task automatic test_frame();
    logic [7:0] em;
    logic       es, ee;
    int col, row;
    do_reset();
    threshold_i = 8'd15;
    stream_const(258, 16'd100, 16'd100);  // full frame + 2 pixels of the next
    drain();
    n_chk++; if (q_mag.size() != 258) begin n_fail++; $display("FAIL frame_count: got %0d want 258", q_mag.size()); end
    for (int i = 0; i < 258 && i < q_mag.size(); i++) begin
      col = i % 16; row = (i / 16) % 16;
      em  = (col < 2 || row < 2) ? 8'd0 : EXP_100;
      ee  = (col < 2 || row < 2) ? 1'b0 : 1'b1;
      es  = (i == 0 || i == 256);
      n_chk++; if (q_mag[i] !== em) begin n_fail++; $display("FAIL frame_mag[%0d]: got %0d want %0d", i, q_mag[i], em); end
      n_chk++; if (q_edge[i] !== ee) begin n_fail++; $display("FAIL frame_edge[%0d]: got %b want %b", i, q_edge[i], ee); end
      n_chk++; if (q_sof[i] !== es) begin n_fail++; $display("FAIL frame_sof[%0d]: got %b want %b", i, q_sof[i], es); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [7:0] hold_mag;
    logic       held, acc, saw_low;
    int k, c;
    do_reset();
    threshold_i = 8'd15;
    stream_const(34, 16'd0, 16'd0);       // advance to col 2, row 2
    drain();
    clear_q();
    pat = 4'b1001;                        // ready_i: 1,0,0,1 per cycle
    k = 0; c = 0; held = 1'b0; saw_low = 1'b0; hold_mag = '0;
    valid_i = 1'b1; gy_i = '0;
    while (k < 8 && c < 100) begin
      ready_i = pat[c % 4];
      gx_i = 16'(4 * (k + 1));
      #1;
      if (held) begin
        n_chk++; if (mag_o !== hold_mag) begin n_fail++; $display("FAIL bp_hold: mag %0d want %0d", mag_o, hold_mag); end
      end
      held = valid_o && !ready_i;
      hold_mag = mag_o;
      if (!ready_o) saw_low = 1'b1;
      acc = ready_o;
      @(posedge clk_i); #1;
      if (acc) k++;
      c++;
    end
    valid_i = 1'b0;
    drain();
    n_chk++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL bp_ready_low: saw %b want 1", saw_low); end
    n_chk++; if (q_mag.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", q_mag.size()); end
    for (int i = 0; i < 8 && i < q_mag.size(); i++) begin
      n_chk++; if (q_mag[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, q_mag[i], i + 1); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    threshold_i = 8'd15;
    stream_const(9, 16'd100, 16'd100);    // next offered pixel is col 9
    valid_i = 1'b1;
    rstn_i = 1'b0;
    #1;
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", valid_o); end
    n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b want 1", ready_o); end
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    clear_q();
    stream_const(1, 16'd100, 16'd100);
    drain();
    n_chk++; if (q_mag.size() != 1) begin n_fail++; $display("FAIL mrst_count: got %0d want 1", q_mag.size()); end
    if (q_mag.size() > 0) begin
      n_chk++; if (q_sof[0] !== 1'b1) begin n_fail++; $display("FAIL mrst_sof: got %b want 1", q_sof[0]); end
      n_chk++; if (q_mag[0] !== 8'd0) begin n_fail++; $display("FAIL mrst_mag: got %0d want 0", q_mag[0]); end
      n_chk++; if (q_edge[0] !== 1'b0) begin n_fail++; $display("FAIL mrst_edge: got %b want 0", q_edge[0]); end
    end
  endtask

  initial begin
    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    gx_i = '0; gy_i = '0; threshold_i = '0;
    test_reset();
    test_basic();
    test_frame();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
